noise_channel: RTL and testbench
================================

// Module: noise_channel
// PURPOSE
//  Game Boy APU channel 4 (pseudo-random noise) for the sound-chip core.
//  - 15/7-bit LFSR stepped by a programmable frequency timer; length counter; optional volume envelope.
//  - Outputs a 1-bit noise level plus a 4-bit volume for the downstream mixer/DAC (swDac in sim).
// PARAMETERS
//  ENV_DIV  4  lenClk pulses per envelope step (256 Hz / 4 = 64 Hz)
// PORTS
//  clk        in   1  4.194 MHz system clock; all state on rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  lenClk     in   1  256 Hz frame tick, synchronous to clk, rising-edge detected
//  length     in   6  length data L; counter loads 64-L on trigger
//  initVol    in   4  initial envelope volume
//  envAdd     in   1  envelope direction: 1 = increase, 0 = decrease
//  envPeriod  in   3  envelope period in env steps; 0 = envelope frozen
//  clkShift   in   4  frequency shift s
//  widthMode  in   1  1 = 7-bit LFSR, 0 = 15-bit
//  divCode    in   3  divisor code r
//  trigger    in   1  restart request, rising-edge detected
//  lenEnable  in   1  1 = length counter may silence channel
//  noise      out  1  channel level: enabled & ~lfsr[0]
//  vol        out  4  current volume (0 while disabled)
// BEHAVIOUR
//  - Reset: lfsr=15'h7FFF, enabled=0, noise=0, vol=0, all counters and edge registers 0.
//  - trig_q and lenclk_q sample their inputs each clk; both reset to 0.
//    A trigger held high out of reset therefore fires once on the first clk edge.
//  - Trigger edge (trigger & ~trig_q) loads, on that edge:
//    lfsr=7FFF, timer=period, lenCnt=64-L (L=0 -> 64), vol=initVol, envCnt=envPeriod, enabled=1.
//  - Period in clks = (r==0 ? 8 : 16*r) << s; widths sized for max 112<<15.
//  - Timer decrements every clk while enabled. On reaching 1 it reloads the period and steps the LFSR:
//    x = lfsr[0]^lfsr[1]; lfsr = {x, lfsr[14:1]}; if widthMode, lfsr[6] = x also.
//  - First LFSR step occurs exactly one period after the trigger edge.
//  - Period inputs changed mid-run take effect at the next reload.
//  - lenClk edge: if lenEnable & lenCnt!=0, lenCnt-1; on reaching 0, enabled=0 on the same edge.
//  - Trigger and lenClk edge in the same cycle: trigger wins (reload, no decrement).
//  - While disabled: LFSR and timer hold; noise=0; vol=0.
//  - noise is registered: it reflects the lfsr/enabled state after each edge.
//  - lenCnt==0 with lenEnable=0: channel keeps playing.
// CONFIGURATION
//  NOISE_ENVELOPE_EN defined:
//   - Internal divider counts lenClk edges; every ENV_DIV edges is one env step.
//   - Each env step decrements envCnt; at 0 it reloads envPeriod and vol moves +/-1 per envAdd.
//   - vol saturates at 15 / 0; envPeriod=0 freezes vol.
//  NOISE_ENVELOPE_EN undefined:
//   - vol = initVol while enabled, else 0; no envelope logic synthesized.
// TESTING
//  - Reset low mid-run -> noise=0, vol=0, lfsr=7FFF on the asserting edge, regardless of clk.
//  - r=0, s=0, width=0, trigger held 1 from reset -> LFSR steps every 8 clks.
//    noise=0 for the first 14 steps; noise=1 after step 15 (clk 120).
//  - widthMode=1, r=0, s=0 -> noise sequence period 127 steps (1016 clks); widthMode=0 -> 32767 steps.
//  - r=2, s=3 -> steps every 256 clks; check with a timestamp counter across 4 steps.
//  - L=63, lenEnable=1 -> channel disabled on first lenClk edge after trigger.
//    noise stays 0; a second trigger edge re-enables.
//  - NOISE_ENVELOPE_EN, initVol=15, envAdd=0, envPeriod=1 -> vol 15,14,13 on every 4th lenClk edge; stops at 0.

Source files
------------

// File: rtl/noise_channel.sv
// Pseudo-random noise channel: 15/7-bit LFSR clocked by a programmable period timer,
// with a length counter and an optional volume envelope (enable with NOISE_ENVELOPE_EN).
module noise_channel #(
  parameter int ENV_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lenClk,
  input  logic [5:0] length,
  input  logic [3:0] initVol,
  input  logic       envAdd,
  input  logic [2:0] envPeriod,
  input  logic [3:0] clkShift,
  input  logic       widthMode,
  input  logic [2:0] divCode,
  input  logic       trigger,
  input  logic       lenEnable,
  output logic       noise,
  output logic [3:0] vol
);

  logic        trig_q;
  logic        lenclk_q;
  logic [14:0] lfsr_reg;
  logic [21:0] timer_reg;
  logic [6:0]  len_cnt_reg;
  logic        enabled_reg;
  logic        noise_reg;

  logic [14:0] lfsr_next;
  logic [21:0] timer_next;
  logic [6:0]  len_cnt_next;
  logic        enabled_next;

  logic        trig_edge;
  logic        len_edge;
  logic [6:0]  base_period;
  logic [21:0] period;
  logic        lfsr_fb;
  logic [14:0] lfsr_step;

  assign trig_edge = trigger & ~trig_q;
  assign len_edge  = lenClk & ~lenclk_q;

  // Largest period is 112 << 15, which needs 22 bits.
  assign base_period = (divCode == 3'd0) ? 7'd8 : {divCode, 4'b0000};
  assign period      = {15'd0, base_period} << clkShift;

  assign lfsr_fb = lfsr_reg[0] ^ lfsr_reg[1];

  always_comb begin
    lfsr_step = {lfsr_fb, lfsr_reg[14:1]};
    if (widthMode) lfsr_step[6] = lfsr_fb;
  end

  always_comb begin
    lfsr_next    = lfsr_reg;
    timer_next   = timer_reg;
    len_cnt_next = len_cnt_reg;
    enabled_next = enabled_reg;
    if (trig_edge) begin
      lfsr_next    = 15'h7FFF;
      timer_next   = period;
      len_cnt_next = 7'd64 - {1'b0, length};
      enabled_next = 1'b1;
    end else begin
      if (enabled_reg) begin
        if (timer_reg == 22'd1) begin
          timer_next = period;
          lfsr_next  = lfsr_step;
        end else begin
          timer_next = timer_reg - 22'd1;
        end
      end
      // A trigger on the same edge wins, so the length tick only applies here.
      if (len_edge && lenEnable && (len_cnt_reg != 7'd0)) begin
        len_cnt_next = len_cnt_reg - 7'd1;
        if (len_cnt_reg == 7'd1) enabled_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_q      <= 1'b0;
      lenclk_q    <= 1'b0;
      lfsr_reg    <= 15'h7FFF;
      timer_reg   <= 22'd0;
      len_cnt_reg <= 7'd0;
      enabled_reg <= 1'b0;
      noise_reg   <= 1'b0;
    end else begin
      trig_q      <= trigger;
      lenclk_q    <= lenClk;
      lfsr_reg    <= lfsr_next;
      timer_reg   <= timer_next;
      len_cnt_reg <= len_cnt_next;
      enabled_reg <= enabled_next;
      noise_reg   <= enabled_next & ~lfsr_next[0];
    end
  end

  assign noise = noise_reg;

`ifdef NOISE_ENVELOPE_EN
  localparam int DIV_W = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;

  logic [DIV_W-1:0] env_div_reg;
  logic [2:0]       env_cnt_reg;
  logic [3:0]       env_vol_reg;
  logic             div_wrap;
  logic             env_tick;

  assign div_wrap = (env_div_reg == DIV_W'(ENV_DIV - 1));
  assign env_tick = len_edge & div_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      env_div_reg <= '0;
      env_cnt_reg <= 3'd0;
      env_vol_reg <= 4'd0;
    end else begin
      if (len_edge) env_div_reg <= div_wrap ? '0 : env_div_reg + DIV_W'(1);
      if (trig_edge) begin
        env_cnt_reg <= envPeriod;
        env_vol_reg <= initVol;
      end else if (env_tick && enabled_reg && (envPeriod != 3'd0)) begin
        if (env_cnt_reg <= 3'd1) begin
          env_cnt_reg <= envPeriod;
          if (envAdd && (env_vol_reg != 4'd15))
            env_vol_reg <= env_vol_reg + 4'd1;
          else if (!envAdd && (env_vol_reg != 4'd0))
            env_vol_reg <= env_vol_reg - 4'd1;
        end else begin
          env_cnt_reg <= env_cnt_reg - 3'd1;
        end
      end
    end
  end

  assign vol = enabled_reg ? env_vol_reg : 4'd0;
`else
  logic env_unused;
  assign env_unused = (^{envAdd, envPeriod}) ^ (ENV_DIV == 0);
  assign vol = enabled_reg ? initVol : 4'd0;
`endif

endmodule

// File: tb/tb_noise_channel.sv
// Self-checking bench for noise_channel: directed scenarios plus randomized runs,
// compared every clock against an event-level reference model.
module tb_noise_channel;

  logic       clk;
  logic       rst_n;
  logic       lenClk;
  logic [5:0] length;
  logic [3:0] initVol;
  logic       envAdd;
  logic [2:0] envPeriod;
  logic [3:0] clkShift;
  logic       widthMode;
  logic [2:0] divCode;
  logic       trigger;
  logic       lenEnable;
  logic       noise;
  logic [3:0] vol;

  noise_channel dut (
    .clk(clk), .rst_n(rst_n), .lenClk(lenClk), .length(length), .initVol(initVol),
    .envAdd(envAdd), .envPeriod(envPeriod), .clkShift(clkShift), .widthMode(widthMode),
    .divCode(divCode), .trigger(trigger), .lenEnable(lenEnable), .noise(noise), .vol(vol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: time in clock edges, scheduled next LFSR step time.
  int m_now, m_next, m_lfsr, m_len;
  bit m_en, m_trig_prev, m_len_prev;
  int m_div, m_ecnt, m_evol;

  function automatic int period_of(input logic [2:0] r, input logic [3:0] s);
    int b;
    b = (r == 3'd0) ? 8 : 16 * int'(r);
    return b << s;
  endfunction

  function automatic int lfsr_adv(input int v, input bit w);
    int x;
    x = (v ^ (v >> 1)) & 1;
    v = (v >> 1) | (x << 14);
    if (w) v = (v & ~(1 << 6)) | (x << 6);
    return v;
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en = 1'b0; m_trig_prev = 1'b0; m_len_prev = 1'b0;
    m_lfsr = 32'h7FFF; m_len = 0; m_div = 0; m_ecnt = 0; m_evol = 0;
  endtask

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    bit te, le, env_step;
    te = trigger && !m_trig_prev;
    le = lenClk && !m_len_prev;
    env_step = 1'b0;
    m_now++;
    if (le) begin
      m_div = (m_div + 1) % 4;
      env_step = (m_div == 0);
    end
    if (te) begin
      m_lfsr = 32'h7FFF;
      m_next = m_now + period_of(divCode, clkShift);
      m_len  = 64 - int'(length);
      m_en   = 1'b1;
      m_ecnt = int'(envPeriod);
      m_evol = int'(initVol);
    end else begin
      if (m_en && m_now == m_next) begin
        m_lfsr = lfsr_adv(m_lfsr, widthMode);
        m_next = m_now + period_of(divCode, clkShift);
      end
      if (env_step && m_en && envPeriod != 3'd0) begin
        if (m_ecnt <= 1) begin
          m_ecnt = int'(envPeriod);
          if (envAdd && m_evol < 15) m_evol++;
          else if (!envAdd && m_evol > 0) m_evol--;
        end else begin
          m_ecnt--;
        end
      end
      if (le && lenEnable && m_len != 0) begin
        m_len--;
        if (m_len == 0) m_en = 1'b0;
      end
    end
    m_trig_prev = trigger;
    m_len_prev  = lenClk;
  endtask

  function automatic logic [3:0] exp_vol();
`ifdef NOISE_ENVELOPE_EN
    return m_en ? 4'(m_evol) : 4'd0;
`else
    return m_en ? initVol : 4'd0;
`endif
  endfunction

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check({tag, "_noise"}, {3'b0, noise}, {3'b0, m_en & ~m_lfsr[0]});
    check({tag, "_vol"}, vol, exp_vol());
  endtask

  task automatic do_trigger(input string tag);
    trigger = 1'b0;
    tick(tag);
    trigger = 1'b1;
    tick(tag);
  endtask

  initial begin
    rst_n = 1'b0; trigger = 1'b1; lenClk = 1'b0; length = 6'd0; initVol = 4'hA;
    envAdd = 1'b0; envPeriod = 3'd0; clkShift = 4'd0; widthMode = 1'b0; divCode = 3'd0;
    lenEnable = 1'b0;
    m_now = 0; m_next = 0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check("reset_noise", {3'b0, noise}, 4'd0);
    check("reset_vol", vol, 4'd0);
    rst_n = 1'b1;

    // Trigger held from reset: steps every 8 clocks, noise rises after step 15.
    repeat (120) tick("r0s0");
    check("step14_noise", {3'b0, noise}, 4'd0);
    tick("r0s0");
    check("step15_noise", {3'b0, noise}, 4'd1);
    check("run_vol", vol, 4'hA);

    // Asynchronous reset mid-cycle while noise is high.
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_noise", {3'b0, noise}, 4'd0);
    check("async_rst_vol", vol, 4'd0);
    model_reset();
    #1 rst_n = 1'b1;
    repeat (130) tick("post_rst");

    // 7-bit mode over two full sequence periods.
    widthMode = 1'b1;
    do_trigger("w7");
    repeat (2100) tick("w7");

    // r=2, s=3: 256-clock period, the 15th step is the first visible noise change.
    widthMode = 1'b0; divCode = 3'd2; clkShift = 4'd3;
    do_trigger("r2s3");
    repeat (15 * 256 - 1) tick("r2s3");
    check("r2s3_pre_noise", {3'b0, noise}, 4'd0);
    tick("r2s3");
    check("r2s3_step15_noise", {3'b0, noise}, 4'd1);
    repeat (40) tick("r2s3");

    // Length counter: L=63 disables on the first lenClk edge.
    divCode = 3'd0; clkShift = 4'd0; length = 6'd63; lenEnable = 1'b1; initVol = 4'h7;
    do_trigger("len");
    repeat (3) tick("len");
    lenClk = 1'b1;
    tick("len");
    check("len_off_vol", vol, 4'd0);
    check("len_off_noise", {3'b0, noise}, 4'd0);
    lenClk = 1'b0;
    repeat (200) tick("len_off");
    do_trigger("retrig");
    check("retrig_vol", vol, 4'h7);

    // Trigger and lenClk edge on the same clock: trigger wins.
    trigger = 1'b0; lenClk = 1'b0;
    tick("tw");
    trigger = 1'b1; lenClk = 1'b1;
    tick("tw");
    check("trig_wins_vol", vol, 4'h7);
    lenClk = 1'b0;
    tick("tw");
    lenClk = 1'b1;
    tick("tw");
    check("len_after_vol", vol, 4'd0);
    lenClk = 1'b0;

    // lenEnable=0: length edges never silence the channel.
    lenEnable = 1'b0;
    do_trigger("len_dis");
    for (int i = 0; i < 5; i++) begin
      lenClk = 1'b1; tick("len_dis");
      lenClk = 1'b0; tick("len_dis");
    end
    check("len_dis_vol", vol, 4'h7);

    // Randomized runs, including mid-run period changes and random length ticks.
    for (int run = 0; run < 8; run++) begin
      divCode   = 3'($urandom_range(0, 3));
      clkShift  = 4'($urandom_range(0, 1));
      widthMode = 1'($urandom_range(0, 1));
      initVol   = 4'($urandom_range(0, 15));
      length    = 6'($urandom_range(40, 63));
      lenEnable = ($urandom_range(0, 2) == 0);
      envAdd    = 1'($urandom_range(0, 1));
      envPeriod = 3'($urandom_range(0, 7));
      lenClk    = 1'b0;
      do_trigger("rnd");
      for (int i = 0; i < 1500; i++) begin
        lenClk = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 299) == 0) begin
          divCode  = 3'($urandom_range(0, 3));
          clkShift = 4'($urandom_range(0, 1));
        end
        tick("rnd");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
